// File: rtl/fwd_hazard_if.sv
// ID-stage decoded fields, EX..WB result taps and bypass/stall results
// exchanged between the decode stage and fwd_hazard_unit.
interface fwd_hazard_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned NSTG    = 3,
  parameter int unsigned CNT_W   = 16
);
  logic                     id_valid;
  logic [RADDR_W:0]         src_a_tag;
  logic                     src_a_use;
  logic [RADDR_W:0]         src_b_tag;
  logic                     src_b_use;
  logic [RADDR_W:0]         dst_tag;
  logic                     dst_we;
  logic                     dst_is_load;
  logic [DATA_W-1:0]        rf_a;
  logic [DATA_W-1:0]        rf_b;
  logic [NSTG*DATA_W-1:0]   stage_data;
  logic                     flush;
  logic                     pipe_hold;
  logic                     fwd_en;
  logic [DATA_W-1:0]        op_a;
  logic [DATA_W-1:0]        op_b;
  logic [2:0]               fwd_sel_a;
  logic [2:0]               fwd_sel_b;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output id_valid, src_a_tag, src_a_use, src_b_tag, src_b_use, dst_tag, dst_we,
           dst_is_load, rf_a, rf_b, stage_data, flush, pipe_hold, fwd_en,
    input  op_a, op_b, fwd_sel_a, fwd_sel_b, stall, stall_cnt
  );

  modport slave (
    input  id_valid, src_a_tag, src_a_use, src_b_tag, src_b_use, dst_tag, dst_we,
           dst_is_load, rf_a, rf_b, stage_data, flush, pipe_hold, fwd_en,
    output op_a, op_b, fwd_sel_a, fwd_sel_b, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use interlock with its own shadow pipeline of
// in-flight destination tags (EX..WB), plus a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RADDR_W  = 3,
  parameter int unsigned NSTG     = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  fwd_hazard_if.slave bus
);
  localparam int unsigned TagW = RADDR_W + 1;

  logic [NSTG-1:0] v_q;
  logic [NSTG-1:0] ld_q;
  logic [TagW-1:0] tag_q [NSTG];
  logic [CNT_W-1:0] cnt_q;

  logic [TagW-1:0]   src_tag [2];
  logic [1:0]        src_use;
  logic [DATA_W-1:0] src_rf  [2];
  logic [DATA_W-1:0] op      [2];
  logic [2:0]        sel     [2];
  logic [1:0]        hazard;
  logic              stall;
  logic              push_v;

  assign src_tag[0] = bus.src_a_tag;
  assign src_tag[1] = bus.src_b_tag;
  assign src_use    = {bus.src_b_use, bus.src_a_use};
  assign src_rf[0]  = bus.rf_a;
  assign src_rf[1]  = bus.rf_b;

  // Only the youngest matching stage is considered; older copies are stale.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      logic found;
      found     = 1'b0;
      hazard[s] = 1'b0;
      sel[s]    = 3'd0;
      op[s]     = src_rf[s];
      for (int k = 0; k < int'(NSTG); k++) begin
        if (!found && v_q[k] && (tag_q[k] == src_tag[s]) && src_use[s] && bus.id_valid) begin
          found = 1'b1;
          if (!bus.fwd_en || (ld_q[k] && (k < int'(LOAD_LAT)))) begin
            hazard[s] = 1'b1;
          end else begin
            sel[s] = 3'(k + 1);
            op[s]  = bus.stage_data[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign stall  = (|hazard) & ~bus.flush;
  assign push_v = bus.id_valid & bus.dst_we & ~stall & ~bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < int'(NSTG); k++) tag_q[k] <= '0;
    end else if (!bus.pipe_hold) begin
      v_q      <= {v_q[NSTG-2:0], push_v};
      ld_q     <= {ld_q[NSTG-2:0], bus.dst_is_load};
      tag_q[0] <= bus.dst_tag;
      for (int k = 1; k < int'(NSTG); k++) tag_q[k] <= tag_q[k-1];
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.op_a      = op[0];
  assign bus.op_b      = op[1];
  assign bus.fwd_sel_a = sel[0];
  assign bus.fwd_sel_b = sel[1];
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus random stimulus against an in-flight instruction model;
// a second instance with a 4-bit counter exercises saturation.
module tb_fwd_hazard_unit;
  localparam int unsigned NSTG = 3;
  localparam int unsigned LL   = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fwd_hazard_if #(.DATA_W(16), .RADDR_W(3), .NSTG(NSTG), .CNT_W(16)) bus ();
  fwd_hazard_if #(.DATA_W(16), .RADDR_W(3), .NSTG(NSTG), .CNT_W(4))  sbus ();

  fwd_hazard_unit #(.DATA_W(16), .RADDR_W(3), .NSTG(NSTG), .LOAD_LAT(LL), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fwd_hazard_unit #(.DATA_W(16), .RADDR_W(3), .NSTG(NSTG), .LOAD_LAT(LL), .CNT_W(4)) sat_dut (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  assign sbus.id_valid    = bus.id_valid;
  assign sbus.src_a_tag   = bus.src_a_tag;
  assign sbus.src_a_use   = bus.src_a_use;
  assign sbus.src_b_tag   = bus.src_b_tag;
  assign sbus.src_b_use   = bus.src_b_use;
  assign sbus.dst_tag     = bus.dst_tag;
  assign sbus.dst_we      = bus.dst_we;
  assign sbus.dst_is_load = bus.dst_is_load;
  assign sbus.rf_a        = bus.rf_a;
  assign sbus.rf_b        = bus.rf_b;
  assign sbus.stage_data  = bus.stage_data;
  assign sbus.flush       = bus.flush;
  assign sbus.pipe_hold   = bus.pipe_hold;
  assign sbus.fwd_en      = bus.fwd_en;

  // Model: one record per in-flight instruction, index 0 = EX.
  bit       m_v   [NSTG];
  bit [3:0] m_tag [NSTG];
  bit       m_ld  [NSTG];
  longint   m_cnt;
  bit       exp_stall;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_src(input logic [3:0] t, input logic u, input logic [15:0] rf,
                                    output bit haz, output logic [2:0] sel,
                                    output logic [15:0] op);
    haz = 0;
    sel = 3'd0;
    op  = rf;
    if (!(u && bus.id_valid)) return;
    for (int k = 0; k < int'(NSTG); k++) begin
      if (m_v[k] && m_tag[k] == t) begin
        if (!bus.fwd_en || (m_ld[k] && k < int'(LL))) haz = 1;
        else begin
          sel = 3'(k + 1);
          op  = bus.stage_data[k*16 +: 16];
        end
        return;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < int'(NSTG); k++) begin
      m_v[k] = 0; m_tag[k] = 4'd0; m_ld[k] = 0;
    end
    m_cnt = 0;
  endfunction

  // Called at negedge with inputs set: check outputs, clock once, advance the model.
  task automatic cycle();
    bit ha, hb;
    logic [2:0] sa, sb;
    logic [15:0] oa, ob;
    #1;
    model_src(bus.src_a_tag, bus.src_a_use, bus.rf_a, ha, sa, oa);
    model_src(bus.src_b_tag, bus.src_b_use, bus.rf_b, hb, sb, ob);
    exp_stall = (ha | hb) & ~bus.flush;
    chk("stall", 32'(bus.stall), 32'(exp_stall));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt > 65535 ? 65535 : m_cnt));
    chk("sat_cnt", 32'(sbus.stall_cnt), 32'(m_cnt > 15 ? 15 : m_cnt));
    if (!ha) begin
      chk("fwd_sel_a", 32'(bus.fwd_sel_a), 32'(sa));
      chk("op_a", 32'(bus.op_a), 32'(oa));
    end
    if (!hb) begin
      chk("fwd_sel_b", 32'(bus.fwd_sel_b), 32'(sb));
      chk("op_b", 32'(bus.op_b), 32'(ob));
    end
    @(posedge clk);
    if (!bus.pipe_hold) begin
      for (int k = int'(NSTG) - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_tag[k] = m_tag[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[0]   = bus.id_valid & bus.dst_we & ~exp_stall & ~bus.flush;
      m_tag[0] = bus.dst_tag;
      m_ld[0]  = bus.dst_is_load;
      if (exp_stall) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic instr(input logic [3:0] a, input logic au, input logic [3:0] b, input logic bu,
                       input logic [3:0] d, input logic we, input logic ld);
    bus.id_valid = 1'b1;
    bus.src_a_tag = a; bus.src_a_use = au;
    bus.src_b_tag = b; bus.src_b_use = bu;
    bus.dst_tag = d; bus.dst_we = we; bus.dst_is_load = ld;
    bus.rf_a = 16'($urandom); bus.rf_b = 16'($urandom);
    bus.stage_data = {16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  task automatic nop();
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    bus.id_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    bus.flush = 1'b0; bus.pipe_hold = 1'b0; bus.fwd_en = 1'b1;
    nop();
    #12 rst = 1'b1;
    @(negedge clk);
    chk("reset_stall", 32'(bus.stall), 32'd0);
    chk("reset_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("reset_sel_a", 32'(bus.fwd_sel_a), 32'd0);
    nop(); cycle();

    // 1: ALU back-to-back
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0); cycle();
    instr(4'd1, 1'b1, 4'd0, 1'b0, 4'd6, 1'b0, 1'b0);
    bus.stage_data[15:0] = 16'h1234;
    #1;
    chk("t1_op_a", 32'(bus.op_a), 32'h1234);
    chk("t1_sel_a", 32'(bus.fwd_sel_a), 32'd1);
    chk("t1_stall", 32'(bus.stall), 32'd0);
    cycle();
    nop(); cycle(); nop(); cycle(); nop(); cycle();

    // 2: load-use, reader held in ID while stalled
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1); cycle();
    instr(4'd3, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    #1 chk("t2_stall", 32'(bus.stall), 32'd1);
    cycle();
    #1 chk("t2_sel", 32'(bus.fwd_sel_a), 32'd2);
    chk("t2_op", 32'(bus.op_a), 32'(bus.stage_data[31:16]));
    cycle();
    nop(); cycle(); nop(); cycle(); nop(); cycle();

    // 3: R2 written twice in flight
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0); cycle();
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0); cycle();
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0); cycle();
    instr(4'd0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0);
    bus.stage_data = {16'h5555, 16'h7777, 16'hAAAA};
    #1 chk("t3_op_b", 32'(bus.op_b), 32'hAAAA);
    chk("t3_sel_b", 32'(bus.fwd_sel_b), 32'd1);
    cycle();
    nop(); cycle(); nop(); cycle(); nop(); cycle();

    // 4: SP in EX must not alias GPR R1
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'b1001, 1'b1, 1'b0); cycle();
    instr(4'b0001, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1 chk("t4_sel_a", 32'(bus.fwd_sel_a), 32'd0);
    chk("t4_op_a", 32'(bus.op_a), 32'(bus.rf_a));
    cycle();
    nop(); cycle(); nop(); cycle(); nop(); cycle();

    // 5: interlock-only mode stalls until the writer leaves WB
    bus.fwd_en = 1'b0;
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0); cycle();
    instr(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    #1 chk("t5_free", 32'(bus.stall), 32'd0);
    chk("t5_cnt", 32'(bus.stall_cnt), 32'd4);
    cycle();
    bus.fwd_en = 1'b1;
    nop(); cycle(); nop(); cycle(); nop(); cycle();

    // 6a: flush beats hazard
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1); cycle();
    instr(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    bus.flush = 1'b1;
    #1 chk("t6_flush", 32'(bus.stall), 32'd0);
    cycle();
    bus.flush = 1'b0;
    nop(); cycle(); nop(); cycle(); nop(); cycle();

    // 6b: pipe_hold during load-use
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1); cycle();
    instr(4'd0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    bus.pipe_hold = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    bus.pipe_hold = 1'b0;
    cycle(); cycle();
    nop(); cycle(); nop(); cycle(); nop(); cycle();

    // Random traffic; also drives the 4-bit counter into saturation
    for (int i = 0; i < 1500; i++) begin
      instr(4'($urandom) & 4'b1011, 1'($urandom), 4'($urandom) & 4'b1011, 1'($urandom),
            4'($urandom) & 4'b1011, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0));
      bus.id_valid  = 1'($urandom_range(0, 9) != 0);
      bus.fwd_en    = 1'($urandom_range(0, 3) != 0);
      bus.flush     = 1'($urandom_range(0, 9) == 0);
      bus.pipe_hold = 1'($urandom_range(0, 9) == 0);
      cycle();
    end
    bus.flush = 1'b0; bus.pipe_hold = 1'b0; bus.fwd_en = 1'b0;
    chk("sat_reached", 32'(sbus.stall_cnt), 32'hF);

    // Reset asserted while stalled
    nop(); cycle(); nop(); cycle(); nop(); cycle();
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0); cycle();
    instr(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1 chk("rst_pre_stall", 32'(bus.stall), 32'd1);
    rst = 1'b0;
    #1 chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_sat_cnt", 32'(sbus.stall_cnt), 32'd0);
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    bus.fwd_en = 1'b1;
    cycle(); nop(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
